multi_axis_step_ctrl: RTL and testbench

//   Parametrised N-axis stepper controller, successor to the fixed 6-axis control/pulse pair.

---
 rtl/step_ctrl_pkg.sv | 23 ++
 rtl/step_axis.sv | 151 +++++++++++++++
 rtl/multi_axis_step_ctrl.sv | 91 +++++++++
 tb/tb_multi_axis_step_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/step_ctrl_pkg.sv
// rtl/step_ctrl_pkg.sv - shared types and helpers for the multi-axis stepper controller
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOMING = 2'd1,
    MOVING = 2'd2,
    FAULT  = 2'd3
  } axis_state_t;

  typedef enum logic [1:0] {
    MOVE  = 2'd0,
    HOME  = 2'd1,
    ABORT = 2'd2,
    RSVD  = 2'd3
  } cmd_op_t;

  // axis index width; a single-axis build still gets a 1-bit index
  function automatic int axw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/step_axis.sv
// rtl/step_axis.sv - one stepper channel: homing/move FSM, pulse timing, position
module step_axis
  import step_ctrl_pkg::*;
#(
  parameter int CNT_W    = 10,
  parameter int POS_W    = 16,
  parameter int HALF_DIV = 1000,
  parameter int HOME_MAX = 4095
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             go_move,
  input  logic             go_home,
  input  logic             go_abort,
  input  logic             dir,
  input  logic [CNT_W-1:0] count,
  input  logic             stop,
  output axis_state_t      st,
  output logic             pu,
  output logic             dr,
  output logic             mf,
  output logic             busy,
  output logic             homed,
  output logic             fault,
  output logic [POS_W-1:0] pos
);
  localparam int DW = $clog2(HALF_DIV);
  localparam int HW = $clog2(HOME_MAX + 1);
  localparam logic [DW-1:0] HALF_LAST = DW'(HALF_DIV - 1);
  localparam logic [DW-1:0] SETUP     = DW'(1);
  localparam logic [HW-1:0] HOME_LAST = HW'(HOME_MAX);

  axis_state_t      st_d;
  logic             pu_d, dr_d, homed_d, fault_d, abort_pend, abort_d;
  logic [DW-1:0]    cnt, cnt_d;
  logic [CNT_W-1:0] left, left_d;
  logic [HW-1:0]    hcnt, hcnt_d;
  logic [POS_W-1:0] pos_d;

  // Next state: a period starts when PU is low and the half-period counter is spent;
  // that is the only point where Stop is looked at and a new pulse may begin.
  always_comb begin
    st_d    = st;
    pu_d    = pu;
    dr_d    = dr;
    cnt_d   = cnt;
    left_d  = left;
    hcnt_d  = hcnt;
    pos_d   = pos;
    homed_d = homed;
    fault_d = fault;
    abort_d = abort_pend;
    if (cnt != '0) cnt_d = cnt - 1'b1;
    unique case (st)
      IDLE, FAULT: begin
        if (go_home) begin
          st_d    = HOMING;
          dr_d    = 1'b0;
          homed_d = 1'b0;
          fault_d = 1'b0;
          hcnt_d  = '0;
          cnt_d   = SETUP;
          abort_d = 1'b0;
        end else if (st == IDLE && go_move && count != '0) begin
          st_d    = MOVING;
          dr_d    = dir;
          left_d  = count;
          cnt_d   = SETUP;
          abort_d = 1'b0;
        end
      end
      HOMING, MOVING: begin
        if (go_abort && !pu) begin
          st_d  = IDLE;
          cnt_d = '0;
        end else if (pu) begin
          if (go_abort) abort_d = 1'b1;
          if (cnt == '0) begin
            pu_d  = 1'b0;
            cnt_d = HALF_LAST;
            if (abort_pend || go_abort) begin
              st_d    = IDLE;
              cnt_d   = '0;
              abort_d = 1'b0;
            end
          end
        end else if (cnt == '0) begin
          if (st == HOMING) begin
            if (stop) begin
              pos_d   = '0;
              homed_d = 1'b1;
              st_d    = IDLE;
            end else if (hcnt == HOME_LAST) begin
              fault_d = 1'b1;
              st_d    = FAULT;
            end else begin
              pu_d   = 1'b1;
              cnt_d  = HALF_LAST;
              hcnt_d = hcnt + 1'b1;
              pos_d  = pos - 1'b1;
            end
          end else begin
            if (!dr && stop) begin
              pos_d = '0;
              st_d  = IDLE;
            end else if (left == '0) begin
              st_d = IDLE;
            end else begin
              pu_d   = 1'b1;
              cnt_d  = HALF_LAST;
              left_d = left - 1'b1;
              pos_d  = dr ? pos + 1'b1 : pos - 1'b1;
            end
          end
        end
      end
    endcase
  end

  // State and datapath registers; busy/MF are registered alongside the state
  always_ff @(posedge sysclk) begin
    if (!rst) begin
      st         <= HOMING;
      pu         <= 1'b0;
      dr         <= 1'b0;
      cnt        <= SETUP;
      left       <= '0;
      hcnt       <= '0;
      pos        <= '0;
      homed      <= 1'b0;
      fault      <= 1'b0;
      abort_pend <= 1'b0;
      busy       <= 1'b1;
      mf         <= 1'b1;
    end else begin
      st         <= st_d;
      pu         <= pu_d;
      dr         <= dr_d;
      cnt        <= cnt_d;
      left       <= left_d;
      hcnt       <= hcnt_d;
      pos        <= pos_d;
      homed      <= homed_d;
      fault      <= fault_d;
      abort_pend <= abort_d;
      busy       <= (st_d == HOMING) || (st_d == MOVING);
      mf         <= (st_d != FAULT);
    end
  end

endmodule

// File: rtl/multi_axis_step_ctrl.sv
// rtl/multi_axis_step_ctrl.sv - N-axis stepper controller: command decode, init tracking, axes
module multi_axis_step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int N_AXES   = 6,
  parameter int CNT_W    = 10,
  parameter int POS_W    = 16,
  parameter int HALF_DIV = 1000,
  parameter int HOME_MAX = 4095
) (
  input  logic                    sysclk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [axw(N_AXES)-1:0]  cmd_axis,
  input  logic [1:0]              cmd_op,
  input  logic                    cmd_dir,
  input  logic [CNT_W-1:0]        cmd_count,
  input  logic [N_AXES-1:0]       Stop,
  output logic [N_AXES-1:0]       PU,
  output logic [N_AXES-1:0]       MF,
  output logic [N_AXES-1:0]       DR,
  output logic [N_AXES-1:0]       busy,
  output logic [N_AXES-1:0]       homed,
  output logic [N_AXES-1:0]       fault,
  output logic [N_AXES*POS_W-1:0] pos,
  output logic                    init_done
);
  localparam int AXW = axw(N_AXES);
  localparam logic [AXW:0] NAX = (AXW + 1)'(N_AXES);

  axis_state_t st [N_AXES];
  cmd_op_t     op;
  logic        in_range, tgt_idle, tgt_fault, acc;

  assign op       = cmd_op_t'(cmd_op);
  assign in_range = {1'b0, cmd_axis} < NAX;
  assign acc      = cmd_valid && cmd_ready;

  // Readiness depends only on the addressed axis state; out-of-range axes are swallowed
  always_comb begin
    tgt_idle  = 1'b0;
    tgt_fault = 1'b0;
    for (int i = 0; i < N_AXES; i++) begin
      if (cmd_axis == AXW'(i)) begin
        tgt_idle  = (st[i] == IDLE);
        tgt_fault = (st[i] == FAULT);
      end
    end
    cmd_ready = init_done && (op == ABORT || op == RSVD || !in_range || tgt_idle ||
                              (op == HOME && tgt_fault));
  end

  for (genvar i = 0; i < N_AXES; i++) begin : g_axis
    logic sel;
    assign sel = acc && (cmd_axis == AXW'(i));
    step_axis #(
      .CNT_W   (CNT_W),
      .POS_W   (POS_W),
      .HALF_DIV(HALF_DIV),
      .HOME_MAX(HOME_MAX)
    ) u_axis (
      .sysclk  (sysclk),
      .rst     (rst),
      .go_move (sel && op == MOVE),
      .go_home (sel && op == HOME),
      .go_abort(sel && op == ABORT),
      .dir     (cmd_dir),
      .count   (cmd_count),
      .stop    (Stop[i]),
      .st      (st[i]),
      .pu      (PU[i]),
      .dr      (DR[i]),
      .mf      (MF[i]),
      .busy    (busy[i]),
      .homed   (homed[i]),
      .fault   (fault[i]),
      .pos     (pos[i*POS_W +: POS_W])
    );
  end

  // Sticky flag: set the cycle after every axis has finished its power-on homing
  always_ff @(posedge sysclk) begin
    if (!rst) begin
      init_done <= 1'b0;
    end else if (&(homed | fault)) begin
      init_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multi_axis_step_ctrl.sv
// tb/tb_multi_axis_step_ctrl.sv - directed self-checking bench for multi_axis_step_ctrl
module tb_multi_axis_step_ctrl;

  logic        sysclk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_axis;
  logic [1:0]  cmd_op;
  logic        cmd_dir;
  logic [9:0]  cmd_count;
  logic [5:0]  Stop;
  logic [5:0]  PU, MF, DR, busy, homed, fault;
  logic [95:0] pos;
  logic        init_done;

  int n_pass = 0;
  int n_total = 0;

  multi_axis_step_ctrl #(
    .N_AXES(6), .CNT_W(10), .POS_W(16), .HALF_DIV(4), .HOME_MAX(8)
  ) dut (
    .sysclk(sysclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_axis(cmd_axis), .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_count(cmd_count),
    .Stop(Stop), .PU(PU), .MF(MF), .DR(DR), .busy(busy), .homed(homed),
    .fault(fault), .pos(pos), .init_done(init_done)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] posof(input int i);
    return pos[i*16 +: 16];
  endfunction

  // Called just after a falling edge; command is taken on the next rising edge
  task automatic send(input int ax, input logic [1:0] op, input logic d, input int cnt,
                      input logic exp_rdy, input string tag);
    cmd_axis  = 3'(ax);
    cmd_op    = op;
    cmd_dir   = d;
    cmd_count = 10'(cnt);
    cmd_valid = 1'b1;
    #1;
    chk(tag, cmd_ready, exp_rdy);
    @(negedge sysclk);
    cmd_valid = 1'b0;
  endtask

  // Samples one axis on falling edges until busy drops (or the budget runs out)
  task automatic watch(input int ax, input int maxc, input int stop_after,
                       output int rises, output int highs, output int first_rise,
                       output int last_rise, output int fall);
    logic prev;
    prev = 1'b0; rises = 0; highs = 0; first_rise = -1; last_rise = -1; fall = -1;
    for (int n = 0; n < maxc; n++) begin
      if (n > 0) @(negedge sysclk);
      if (PU[ax] && !prev) begin
        rises++;
        if (first_rise < 0) first_rise = n;
        last_rise = n;
        if (rises == stop_after) Stop[ax] = 1'b1;
      end
      if (PU[ax]) highs++;
      prev = PU[ax];
      if (!busy[ax]) begin
        fall = n;
        break;
      end
    end
  endtask

  int thr [6] = '{5, 3, 0, 3, 3, 3};
  int hrise [6];
  logic [5:0] prev_pu;
  int done_cyc;
  int r, h, fr, lr, fl;

  initial begin
    rst = 1'b0; Stop = '0; cmd_valid = 1'b0; cmd_axis = '0; cmd_op = '0;
    cmd_dir = 1'b0; cmd_count = '0;
    repeat (3) @(negedge sysclk);
    chk("rst_pu", PU, 6'h00);
    chk("rst_mf", MF, 6'h3f);
    chk("rst_dr", DR, 6'h00);
    chk("rst_busy", busy, 6'h3f);
    chk("rst_homed", homed, 6'h00);
    chk("rst_fault", fault, 6'h00);
    chk("rst_pos", pos, 96'h0);
    chk("rst_init", init_done, 1'b0);
    chk("rst_ready", cmd_ready, 1'b0);

    // Power-on homing: axis 0 finds its switch after 5 pulses, axis 2 never does
    rst = 1'b1;
    prev_pu = '0;
    hrise = '{default: 0};
    done_cyc = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge sysclk);
      for (int i = 0; i < 6; i++) begin
        if (PU[i] && !prev_pu[i]) begin
          hrise[i]++;
          if (hrise[i] == thr[i]) Stop[i] = 1'b1;
        end
      end
      prev_pu = PU;
      if (done_cyc < 0 && (&(homed | fault))) begin
        done_cyc = c;
        chk("init_done_same_cycle", init_done, 1'b0);
      end else if (done_cyc >= 0) begin
        chk("init_done_next_cycle", init_done, 1'b1);
        break;
      end
    end
    chk("homing_finished", done_cyc >= 0, 1'b1);
    chk("home_pulses_ax0", hrise[0], 5);
    chk("home_pulses_ax1", hrise[1], 3);
    chk("home_pulses_ax2", hrise[2], 8);
    chk("homed_vec", homed, 6'b111011);
    chk("fault_vec", fault, 6'b000100);
    chk("mf_vec", MF, 6'b111011);
    chk("busy_after_home", busy, 6'h00);
    for (int i = 0; i < 6; i++) if (i != 2) chk($sformatf("home_pos_ax%0d", i), posof(i), 16'h0);
    Stop = '0;
    @(negedge sysclk);

    // Command gating after init
    send(2, 2'd0, 1'b1, 3, 1'b0, "move_to_fault_not_ready");
    send(7, 2'd0, 1'b1, 3, 1'b1, "out_of_range_ready");
    send(1, 2'd3, 1'b0, 0, 1'b1, "reserved_ready");
    chk("no_effect_busy", busy, 6'h00);

    // MOVE axis 1, 5 pulses away from the limit
    send(1, 2'd0, 1'b1, 5, 1'b1, "move1_ready");
    chk("move1_dr", DR[1], 1'b1);
    chk("move1_busy", busy[1], 1'b1);
    watch(1, 200, 0, r, h, fr, lr, fl);
    chk("move1_rises", r, 5);
    chk("move1_high_cycles", h, 20);
    chk("move1_first_rise", fr, 2);
    chk("move1_last_rise", lr, 34);
    chk("move1_busy_fall", fl, 42);
    chk("move1_pos", posof(1), 16'd5);

    // Zero-count MOVE: accepted, nothing happens
    send(1, 2'd0, 1'b1, 0, 1'b1, "move0_ready");
    watch(1, 20, 0, r, h, fr, lr, fl);
    chk("move0_rises", r, 0);
    chk("move0_idle", fl, 0);
    chk("move0_pos", posof(1), 16'd5);

    // Axis 3 to +3, then back toward the limit with the switch hit on period 4
    send(3, 2'd0, 1'b1, 3, 1'b1, "move3_up_ready");
    watch(3, 100, 0, r, h, fr, lr, fl);
    chk("move3_up_pos", posof(3), 16'd3);
    send(3, 2'd0, 1'b0, 100, 1'b1, "move3_dn_ready");
    watch(3, 300, 3, r, h, fr, lr, fl);
    chk("move3_dn_rises", r, 3);
    chk("move3_dn_fall", fl, 26);
    chk("move3_dn_pos", posof(3), 16'd0);
    chk("move3_dn_pu", PU[3], 1'b0);
    Stop = '0;

    // ABORT one cycle into the first high half of axis 5
    send(5, 2'd0, 1'b1, 10, 1'b1, "move5_ready");
    @(negedge sysclk);
    @(negedge sysclk);
    chk("abort_pu_rise", PU[5], 1'b1);
    @(negedge sysclk);
    send(5, 2'd2, 1'b0, 0, 1'b1, "abort_ready");
    chk("abort_pu_n4", PU[5], 1'b1);
    chk("abort_busy_n4", busy[5], 1'b1);
    @(negedge sysclk);
    chk("abort_pu_n5", PU[5], 1'b1);
    @(negedge sysclk);
    chk("abort_pu_n6", PU[5], 1'b0);
    chk("abort_busy_n6", busy[5], 1'b0);
    repeat (10) @(negedge sysclk);
    chk("abort_pu_later", PU[5], 1'b0);
    chk("abort_pos", posof(5), 16'd1);

    // Back-to-back moves on axes 0 and 4; a third to busy axis 0 is held off
    send(0, 2'd0, 1'b1, 2, 1'b1, "b2b_ax0_ready");
    send(4, 2'd0, 1'b1, 2, 1'b1, "b2b_ax4_ready");
    send(0, 2'd0, 1'b1, 2, 1'b0, "busy_ax0_not_ready");
    chk("b2b_pu_ax0_first", PU[5:0] & 6'b010001, 6'b000001);
    @(negedge sysclk);
    chk("b2b_overlap", PU[5:0] & 6'b010001, 6'b010001);
    repeat (30) @(negedge sysclk);
    chk("b2b_pos0", posof(0), 16'd2);
    chk("b2b_pos4", posof(4), 16'd2);
    chk("b2b_idle", busy, 6'h00);

    // Re-home the faulted axis 2; its switch closes after 2 pulses
    send(2, 2'd1, 1'b0, 0, 1'b1, "rehome_ready");
    chk("rehome_fault_clr", fault[2], 1'b0);
    chk("rehome_busy", busy[2], 1'b1);
    chk("rehome_mf", MF[2], 1'b1);
    chk("rehome_dr", DR[2], 1'b0);
    watch(2, 200, 2, r, h, fr, lr, fl);
    chk("rehome_rises", r, 2);
    chk("rehome_fall", fl, 18);
    chk("rehome_homed", homed[2], 1'b1);
    chk("rehome_pos", posof(2), 16'h0);
    chk("rehome_init_sticky", init_done, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
